// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the shift-register sequencer.
// Optional pause input is enabled by defining SHIFT_SEQ_CTRL_PAUSE_EN.
package shift_seq_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Requester/shift-register side signals of shift_seq_ctrl.
// SHIFT_SEQ_CTRL_PAUSE_EN adds the pause input.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    import shift_seq_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   req_data0;
    logic [WIDTH-1:0]   req_data1;
    logic               abort;
`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
    logic               pause;
`endif
    logic [NUM_REQ-1:0] gnt;
    logic               load_en;
    logic [WIDTH-1:0]   load_data;
    logic               shift_en;
    logic               busy;
    logic               done;
    logic               done_id;
    logic               aborted;

`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
    modport master (
        output req, req_data0, req_data1, abort, pause,
        input  gnt, load_en, load_data, shift_en, busy, done, done_id, aborted
    );
    modport slave (
        input  req, req_data0, req_data1, abort, pause,
        output gnt, load_en, load_data, shift_en, busy, done, done_id, aborted
    );
`else
    modport master (
        output req, req_data0, req_data1, abort,
        input  gnt, load_en, load_data, shift_en, busy, done, done_id, aborted
    );
    modport slave (
        input  req, req_data0, req_data1, abort,
        output gnt, load_en, load_data, shift_en, busy, done, done_id, aborted
    );
`endif

endinterface

// File: rtl/shift_seq_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; remembers which requester to prefer on a tie.
module rr_arb2
    import shift_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               upd,
    output logic [NUM_REQ-1:0] winner,
    output logic               valid
);

    logic prefer1;

    always_comb begin
        winner = '0;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = prefer1 ? 2'b10 : 2'b01;
            default: winner = '0;
        endcase
        valid = |req;
    end

    // After a grant to requester 0 prefer 1, and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer1 <= 1'b0;
        end else if (upd && valid) begin
            prefer1 <= winner[0];
        end
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Arbitrates two requesters, then issues one load and WIDTH shift strobes per frame.
// Defining SHIFT_SEQ_CTRL_PAUSE_EN enables the pause input (stalls shifting).
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    shift_seq_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               owner;
    logic               aborted_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [WIDTH-1:0]   load_data_q;
    logic [NUM_REQ-1:0] arb_winner;
    logic               arb_valid;
    logic               grant;
    logic               pause_i;
    logic               shift_en;
    logic               load_en;
    logic               done;

`ifdef SHIFT_SEQ_CTRL_PAUSE_EN
    assign pause_i = bus.pause;
`else
    assign pause_i = 1'b0;
`endif

    // Pointer moves at the grant edge; it is only consulted in IDLE, so this
    // is indistinguishable from flipping it on leaving LOAD.
    assign grant = (state == ST_IDLE) && arb_valid;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req),
        .upd    (grant),
        .winner (arb_winner),
        .valid  (arb_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        load_en   = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_valid) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                load_en   = 1'b1;
                state_nxt = bus.abort ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    state_nxt = ST_DONE;
                end else if (!pause_i) begin
                    shift_en = 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= '0;
            load_data_q <= '0;
            owner       <= 1'b0;
            aborted_q   <= 1'b0;
            cnt         <= '0;
        end else begin
            gnt_q <= grant ? arb_winner : '0;
            if (grant) begin
                load_data_q <= arb_winner[1] ? bus.req_data1 : bus.req_data0;
                owner       <= arb_winner[1];
                aborted_q   <= 1'b0;
            end
            if (state == ST_LOAD) begin
                cnt <= '0;
                if (bus.abort) aborted_q <= 1'b1;
            end
            if (state == ST_SHIFT) begin
                if (bus.abort) begin
                    aborted_q <= 1'b1;
                end else if (shift_en) begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.load_en   = load_en;
    assign bus.load_data = load_data_q;
    assign bus.shift_en  = shift_en;
    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done;
    assign bus.done_id   = done & owner;
    assign bus.aborted   = done & aborted_q;

endmodule
